// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg
// Shared types for the GPU core memory path.
//   arb_state_t : state encoding of the per-warp lane memory arbiter.
package gpu_isa_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/lane_ffs.sv
// lane_ffs
// Find-first-set over a lane mask: returns the lowest set lane index.
// Ports:
//   mask  : lane mask (NUM_THREADS bits)
//   index : index of the lowest set bit (0 when mask is empty)
//   any   : 1 when at least one bit of mask is set
module lane_ffs #(
    parameter int NUM_THREADS = 4,
    parameter int IDX_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic [NUM_THREADS-1:0] mask,
    output logic [IDX_W-1:0]       index,
    output logic                   any
);

    // Scan from the top down so the last hit (the lowest index) wins.
    always_comb begin
        index = '0;
        any   = |mask;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lane_mem_arbiter.sv
// lane_mem_arbiter
// Serialises one warp-wide load/store onto a single-port memory, one active
// lane at a time in ascending lane order, and gathers load results per lane.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/req_ready       : warp operation offer / accept (accepted only in IDLE)
//   req_is_store, req_mask    : operation kind and active-lane mask
//   req_addr, req_wdata       : per-lane address and store data
//   resp_valid, resp_rdata    : one-cycle completion pulse, per-lane load data
//   busy                      : operation in flight (core stalls on it)
//   mem_req_*                 : request to shared memory (valid/ready)
//   mem_rsp_valid/rdata       : load response, at most one outstanding
//   o_dbg_state               : current FSM state, for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; once valid is raised, payload stays stable until that edge.
module lane_mem_arbiter
    import gpu_isa_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_is_store,
    input  logic [NUM_THREADS-1:0]                req_mask,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_wdata,
    output logic                                  resp_valid,
    output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] resp_rdata,
    output logic                                  busy,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic                                  mem_req_we,
    output logic [DATA_WIDTH-1:0]                 mem_req_addr,
    output logic [DATA_WIDTH-1:0]                 mem_req_wdata,
    input  logic                                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                 mem_rsp_rdata,
    output arb_state_t                            o_dbg_state
);

    localparam int LW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    arb_state_t                              r_state;
    arb_state_t                              w_next_state;
    logic [NUM_THREADS-1:0]                  r_pending;
    logic                                    r_is_store;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  r_addr;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  r_wdata;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  r_rdata;
    logic [LW-1:0]                           r_lane;

    logic [LW-1:0]          w_ffs_idx;
    logic                   w_ffs_any;
    logic [LW-1:0]          w_cur_lane;
    logic [NUM_THREADS-1:0] w_pending_clr;
    logic                   w_accept;
    logic                   w_mem_fire;
    logic                   w_rsp_fire;

    lane_ffs #(
        .NUM_THREADS (NUM_THREADS),
        .IDX_W       (LW)
    ) u_lane_ffs (
        .mask  (r_pending),
        .index (w_ffs_idx),
        .any   (w_ffs_any)
    );

    // In WAIT_RSP the lane is the one latched at issue; elsewhere it is the
    // lowest still-pending lane.
    assign w_cur_lane    = (r_state == WAIT_RSP) ? r_lane : w_ffs_idx;
    assign w_pending_clr = r_pending & ~(NUM_THREADS'(1) << w_cur_lane);

    assign w_accept   = req_valid && (r_state == IDLE);
    assign w_mem_fire = (r_state == ISSUE) && mem_req_ready;
    assign w_rsp_fire = (r_state == WAIT_RSP) && mem_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        req_ready     = 1'b0;
        busy          = 1'b1;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next_state = (req_mask == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = w_ffs_any;
                if (mem_req_ready) begin
                    if (r_is_store) begin
                        w_next_state = (w_pending_clr == '0) ? DONE : ISSUE;
                    end else begin
                        w_next_state = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    w_next_state = (w_pending_clr == '0) ? DONE : ISSUE;
                end
            end
            DONE: begin
                resp_valid   = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request payload is zero whenever no request is offered.
    assign mem_req_we    = mem_req_valid ? r_is_store : 1'b0;
    assign mem_req_addr  = mem_req_valid ? r_addr[w_ffs_idx] : '0;
    assign mem_req_wdata = mem_req_valid ? r_wdata[w_ffs_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_lane     <= '0;
        end else begin
            if (w_accept) begin
                r_pending  <= req_mask;
                r_is_store <= req_is_store;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rdata    <= '0;
            end
            if (w_mem_fire) begin
                if (r_is_store) begin
                    r_pending <= w_pending_clr;
                end else begin
                    r_lane <= w_ffs_idx;
                end
            end
            if (w_rsp_fire) begin
                r_rdata[r_lane] <= mem_rsp_rdata;
                r_pending       <= w_pending_clr;
            end
        end
    end

    assign resp_rdata  = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lane_mem_arbiter.sv
module tb_lane_mem_arbiter;
  import gpu_isa_pkg::*;

  localparam int NT = 4;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_store;
  logic [NT-1:0]          req_mask;
  logic [NT-1:0][DW-1:0]  req_addr;
  logic [NT-1:0][DW-1:0]  req_wdata;
  logic                   resp_valid;
  logic [NT-1:0][DW-1:0]  resp_rdata;
  logic                   busy;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_we;
  logic [DW-1:0]          mem_req_addr;
  logic [DW-1:0]          mem_req_wdata;
  logic                   mem_rsp_valid;
  logic [DW-1:0]          mem_rsp_rdata;
  arb_state_t             dbg_state;

  lane_mem_arbiter #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_mask      (req_mask),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .busy          (busy),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic          we;
    int            lane;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit                    m_busy;
  bit                    m_done;
  bit                    m_wait;
  int                    m_wait_lane;
  mreq_t                 m_q[$];
  logic [NT-1:0][DW-1:0] m_rdata;
  logic [NT*DW-1:0]      exp_q[$];
  logic [DW-1:0]         mem[16];

  int               acc_cyc;
  int               last_lat;
  logic [NT*DW-1:0] last_rdata;
  logic [2*DW-1:0]  wr_log[$];
  int               mv_cnt;

  int            rsp_cd;
  logic [DW-1:0] rsp_data;
  int            ready_pct;
  int            rsp_delay_max;
  bit            spurious_en;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_wait = 1'b0;
    m_wait_lane = 0;
    m_q.delete();
    m_rdata = '0;
    exp_q.delete();
    rsp_cd = 0;
  endtask

  // Called mid-cycle: compare outputs with the model, then advance the model
  // by what the coming rising edge will do.
  task automatic compare_and_step();
    bit               exp_mv;
    mreq_t            h;
    logic [NT*DW-1:0] fin;
    if (!rst_n) begin
      check("rst_req_ready", 64'(req_ready), 64'(1'b1));
      check("rst_busy", 64'(busy), 64'(1'b0));
      check("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
      check("rst_mem_valid", 64'(mem_req_valid), 64'(1'b0));
      check("rst_rdata", 64'(resp_rdata), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      return;
    end
    exp_mv = m_busy && !m_done && !m_wait && (m_q.size() > 0);
    if (exp_mv) h = m_q[0];
    else h = '{we: 1'b0, lane: 0, addr: '0, wdata: '0};
    if (mem_req_valid) mv_cnt++;

    check("busy", 64'(busy), 64'(m_busy));
    check("req_ready", 64'(req_ready), 64'(!m_busy));
    check("resp_valid", 64'(resp_valid), 64'(m_done));
    check("mem_req_valid", 64'(mem_req_valid), 64'(exp_mv));
    check("mem_req_we", 64'(mem_req_we), 64'(h.we));
    check("mem_req_addr", 64'(mem_req_addr), 64'(h.addr));
    check("mem_req_wdata", 64'(mem_req_wdata), 64'(h.wdata));
    check("resp_rdata", 64'(resp_rdata), 64'(m_rdata));

    if (m_done) begin
      if (exp_q.size() > 0) begin
        fin = exp_q.pop_front();
        check("final_rdata", 64'(resp_rdata), 64'(fin));
      end
      last_rdata = resp_rdata;
      last_lat = cyc - acc_cyc;
    end

    if (!m_busy) begin
      if (req_valid) begin
        acc_cyc = cyc;
        m_busy = 1'b1;
        m_rdata = '0;
        fin = '0;
        for (int l = 0; l < NT; l++) begin
          if (req_mask[l]) begin
            m_q.push_back('{we: req_is_store, lane: l, addr: req_addr[l], wdata: req_wdata[l]});
            if (!req_is_store) fin[l*DW +: DW] = mem[req_addr[l][3:0]];
          end
        end
        exp_q.push_back(fin);
        if (req_mask == '0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (exp_mv) begin
      if (mem_req_ready) begin
        void'(m_q.pop_front());
        if (h.we) begin
          mem[h.addr[3:0]] = h.wdata;
          wr_log.push_back({h.addr, h.wdata});
          if (m_q.size() == 0) m_done = 1'b1;
        end else begin
          m_wait = 1'b1;
          m_wait_lane = h.lane;
          rsp_cd = $urandom_range(1, rsp_delay_max);
          rsp_data = mem[h.addr[3:0]];
        end
      end
    end else if (m_wait && mem_rsp_valid) begin
      m_rdata[m_wait_lane] = mem_rsp_rdata;
      m_wait = 1'b0;
      if (m_q.size() == 0) m_done = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    compare_and_step();
    @(posedge clk);
    cyc++;
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = DW'($urandom);
    if (rsp_cd > 0) begin
      rsp_cd--;
      if (rsp_cd == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp_data;
      end
    end else if (spurious_en && !m_wait && $urandom_range(0, 3) == 0) begin
      mem_rsp_valid = 1'b1;
    end
    mem_req_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic drive_junk_req();
    req_valid = 1'b1;
    req_is_store = 1'($urandom_range(0, 1));
    req_mask = NT'($urandom);
    for (int l = 0; l < NT; l++) begin
      req_addr[l] = DW'($urandom_range(0, 15));
      req_wdata[l] = DW'($urandom);
    end
  endtask

  task automatic finish_op();
    int guard = 0;
    while (m_busy && guard < 300) begin
      tick();
      guard++;
    end
    req_valid = 1'b0;
    if (guard >= 300) check("op_timeout", 64'(1), 64'(0));
  endtask

  task automatic run_op(input logic st, input logic [NT-1:0] mk,
                        input logic [NT-1:0][DW-1:0] ad, input logic [NT-1:0][DW-1:0] wd,
                        input bit junk);
    int guard = 0;
    req_valid = 1'b1;
    req_is_store = st;
    req_mask = mk;
    req_addr = ad;
    req_wdata = wd;
    mv_cnt = 0;
    tick();
    while (m_busy && guard < 300) begin
      if (junk) drive_junk_req();
      else req_valid = 1'b0;
      tick();
      guard++;
    end
    req_valid = 1'b0;
    if (guard >= 300) check("op_timeout", 64'(1), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NT-1:0][DW-1:0] ra;
    logic [NT-1:0][DW-1:0] rw;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_mask = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    ready_pct = 100;
    rsp_delay_max = 1;
    spurious_en = 1'b0;
    last_lat = 0;
    last_rdata = '0;
    acc_cyc = 0;
    mv_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    model_reset();

    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // four-lane store, lanes written in order 0..3
    wr_log.delete();
    run_op(1'b1, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, {16'hD, 16'hC, 16'hB, 16'hA}, 1'b0);
    check("st4_nwrites", 64'(wr_log.size()), 64'(4));
    if (wr_log.size() == 4) begin
      check("st4_wr0", 64'(wr_log[0]), 64'(32'h0000_000A));
      check("st4_wr1", 64'(wr_log[1]), 64'(32'h0001_000B));
      check("st4_wr2", 64'(wr_log[2]), 64'(32'h0002_000C));
      check("st4_wr3", 64'(wr_log[3]), 64'(32'h0003_000D));
    end
    check("st4_latency", 64'(last_lat), 64'(5));
    check("st4_rdata", 64'(last_rdata), 64'(0));

    // sparse load, lanes 0 and 2, one-cycle responses
    mem[8] = 16'h0011;
    mem[9] = 16'h0022;
    run_op(1'b0, 4'b0101, {16'd0, 16'd9, 16'd0, 16'd8}, '0, 1'b0);
    check("ld2_rdata", 64'(last_rdata), 64'h0000_0022_0000_0011);
    check("ld2_latency", 64'(last_lat), 64'(5));

    // empty mask load
    run_op(1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, '0, 1'b0);
    check("m0_latency", 64'(last_lat), 64'(1));
    check("m0_rdata", 64'(last_rdata), 64'(0));
    check("m0_mem_valid", 64'(mv_cnt), 64'(0));

    // lane-1 store stalled by memory, with junk requests and spurious responses
    ready_pct = 0;
    spurious_en = 1'b1;
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_mask = 4'b0010;
    req_addr = {16'd0, 16'd0, 16'd5, 16'd0};
    req_wdata = {16'd0, 16'd0, 16'h1234, 16'd0};
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_junk_req();
      #1;
      check("stall_addr", 64'(mem_req_addr), 64'(16'd5));
      check("stall_wdata", 64'(mem_req_wdata), 64'(16'h1234));
      check("stall_busy", 64'(busy), 64'(1'b1));
      check("stall_ready", 64'(req_ready), 64'(1'b0));
      if (i == 2) ready_pct = 100;
      tick();
    end
    finish_op();
    check("stall_mem5", 64'(mem[5]), 64'(16'h1234));
    spurious_en = 1'b0;

    // reset while waiting for a load response
    rsp_delay_max = 3;
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_mask = 4'b1111;
    req_addr = {16'd7, 16'd6, 16'd5, 16'd4};
    tick();
    req_valid = 1'b0;
    begin
      int guard = 0;
      while (!m_wait && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check("wait_timeout", 64'(1), 64'(0));
    end
    rst_n = 1'b0;
    mem_rsp_valid = 1'b0;
    model_reset();
    #1;
    check("arst_mem_valid", 64'(mem_req_valid), 64'(1'b0));
    check("arst_busy", 64'(busy), 64'(1'b0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rsp_delay_max = 1;
    run_op(1'b0, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, '0, 1'b0);
    check("post_rst_latency", 64'(last_lat), 64'(9));
    check("post_rst_rdata", 64'(last_rdata), 64'({mem[3], mem[2], mem[1], mem[0]}));

    // randomized operations
    ready_pct = 70;
    rsp_delay_max = 3;
    spurious_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      for (int l = 0; l < NT; l++) begin
        ra[l] = DW'($urandom_range(0, 15));
        rw[l] = DW'($urandom);
      end
      run_op(1'($urandom_range(0, 1)), NT'($urandom), ra, rw, 1'b1);
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
